// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - register-file write-port arbiter for write-back and buffered MDU results
// Optional MDU starvation guard enabled by defining WB_STARVE_GUARD_EN.
module wb_port_arbiter #(
  parameter int BUF_DEPTH    = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_we,
  input  logic [4:0]  pipe_rd,
  input  logic [31:0] pipe_data,
  output logic        pipe_hold,
  input  logic        mdu_valid,
  input  logic [4:0]  mdu_rd,
  input  logic [31:0] mdu_data,
  output logic        mdu_ready,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  output logic        issue_ready,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  id_rd,
  input  logic        id_rd_we,
  output logic        hazard_stall,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] DEPTH_C    = CW'(BUF_DEPTH);
  localparam logic [WW-1:0] STARVE_MAX = WW'(STARVE_LIMIT);

  logic [4:0]    buf_rd_q   [BUF_DEPTH];
  logic [4:0]    buf_rd_d   [BUF_DEPTH];
  logic [31:0]   buf_data_q [BUF_DEPTH];
  logic [31:0]   buf_data_d [BUF_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   pending_q, pending_d;
  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  logic          rf_we_q, rf_we_d;
  logic [4:0]    rf_waddr_q, rf_waddr_d;
  logic [31:0]   rf_wdata_q, rf_wdata_d;

  logic        buf_empty;
  logic        buf_full;
  logic        pipe_eff;
  logic        starve;
  logic        grant_pipe;
  logic        pop;
  logic        push;
  logic        push_keep;
  logic        issue_take;
  logic [4:0]  head_rd;
  logic [31:0] head_data;

  assign buf_empty = (count_q == '0);
  assign buf_full  = (count_q == DEPTH_C);
  assign pipe_eff  = pipe_we & (pipe_rd != 5'd0);
  assign head_rd   = buf_rd_q[rd_ptr_q];
  assign head_data = buf_data_q[rd_ptr_q];

`ifdef WB_STARVE_GUARD_EN
  assign starve = !buf_empty & pipe_eff & (wait_cnt_q == STARVE_MAX);
`else
  assign starve = 1'b0;
`endif

  assign grant_pipe = pipe_eff & !starve;
  assign pop        = !grant_pipe & !buf_empty;

  // x0 results complete the handshake but are dropped rather than buffered
  assign push      = mdu_valid & !buf_full;
  assign push_keep = push & (mdu_rd != 5'd0);

  assign issue_ready = !pending_q[issue_rd];
  assign issue_take  = issue_valid & issue_ready & (issue_rd != 5'd0);

  assign mdu_ready    = !buf_full;
  assign pipe_hold    = starve;
  assign hazard_stall = (pending_q[id_rs1] & (id_rs1 != 5'd0))
                      | (pending_q[id_rs2] & (id_rs2 != 5'd0))
                      | (id_rd_we & pending_q[id_rd] & (id_rd != 5'd0))
                      | starve;

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

  always_comb begin
    buf_rd_d   = buf_rd_q;
    buf_data_d = buf_data_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (push_keep) begin
      buf_rd_d[wr_ptr_q]   = mdu_rd;
      buf_data_d[wr_ptr_q] = mdu_data;
      wr_ptr_d             = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push_keep, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Clear before set: an issue to a still-pending rd is refused, so both never hit one bit
  always_comb begin
    pending_d = pending_q;
    if (pop) begin
      pending_d[head_rd] = 1'b0;
    end
    if (issue_take) begin
      pending_d[issue_rd] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (buf_empty || pop) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != STARVE_MAX) begin
      wait_cnt_d = wait_cnt_q + WW'(1);
    end
  end

  always_comb begin
    rf_we_d    = grant_pipe | pop;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (grant_pipe) begin
      rf_waddr_d = pipe_rd;
      rf_wdata_d = pipe_data;
    end else if (pop) begin
      rf_waddr_d = head_rd;
      rf_wdata_d = head_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_rd_q[i]   <= '0;
        buf_data_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      pending_q  <= '0;
      wait_cnt_q <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      buf_rd_q   <= buf_rd_d;
      buf_data_q <= buf_data_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      pending_q  <= pending_d;
      wait_cnt_q <= wait_cnt_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Arbitrates the single register-file write port between two sources: the in-order pipeline write-back stage and a long-latency multiply/divide unit (MDU).
- Buffers MDU results and keeps a scoreboard of destination registers with MDU results still outstanding.
- Gives the decode stage hazard-stall and issue-ready signals.
- Sits between the write-back stage, the MDU result bus and the register file write port.

Parameters:
- BUF_DEPTH, 2, MDU result buffer entries; power of two, minimum 2.
- STARVE_LIMIT, 4, cycles a buffered MDU result may wait before the pipeline is held; used only with WB_STARVE_GUARD_EN.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- pipe_we  input  1  write-back stage write enable.
- pipe_rd  input  5  write-back destination register.
- pipe_data  input  32  write-back data.
- pipe_hold  output  1  the pipe_* write is not taken this cycle; the stage holds its inputs.
- mdu_valid  input  1  MDU result valid.
- mdu_rd  input  5  MDU destination register.
- mdu_data  input  32  MDU result.
- mdu_ready  output  1  buffer can accept an MDU result.
- issue_valid  input  1  decode is issuing an MDU op.
- issue_rd  input  5  destination of that MDU op.
- issue_ready  output  1  MDU issue allowed.
- id_rs1  input  5  decode source register 1.
- id_rs2  input  5  decode source register 2.
- id_rd  input  5  decode destination register.
- id_rd_we  input  1  decode instruction writes id_rd.
- hazard_stall  output  1  decode must stall.
- rf_we  output  1  register file write enable.
- rf_waddr  output  5  register file write address.
- rf_wdata  output  32  register file write data.

Behaviour:
- Reset (async, rst=1): rf_we=0, rf_waddr=0, rf_wdata=0; buffer empty; scoreboard all 0; wait_cnt=0.
  - Combinational outputs with these cleared states: mdu_ready=1, pipe_hold=0, hazard_stall=0, issue_ready=1.
  - Reset mid-operation discards all buffered results and pending bits.
- Register x0 filtering:
  - pipe_eff = pipe_we & (pipe_rd != 0).
  - MDU results and issues with rd=0 are accepted but never written and never set a scoreboard bit.
- Buffer:
  - FIFO of {rd, data}; mdu_ready = !full.
  - Push on mdu_valid & mdu_ready.
  - Push and pop in the same cycle are legal when not full. A full buffer refuses the push even if it pops that cycle.
- Grant:
  - Pipe wins when pipe_eff & !pipe_hold.
  - Otherwise the buffer head pops if the buffer is non-empty.
  - At most one write per cycle.
- Output timing:
  - rf_* are registered: a grant in cycle N produces rf_we/rf_waddr/rf_wdata in cycle N+1.
  - rf_we=0 in cycles with no grant; rf_waddr and rf_wdata then hold their previous values.
- Scoreboard (32 bits, bit 0 is constant 0):
  - Set on issue_valid & issue_ready & issue_rd != 0.
  - Cleared on the cycle the buffer head pops for that rd.
  - issue_ready = !pending[issue_rd], using the registered state, so a same-cycle clear does not raise issue_ready. This blocks an MDU-vs-MDU WAW.
- hazard_stall is the OR of:
  - (pending[id_rs1] & id_rs1 != 0)
  - (pending[id_rs2] & id_rs2 != 0)
  - (id_rd_we & pending[id_rd] & id_rd != 0)
  - pipe_hold
- Stall counter wait_cnt (saturates at STARVE_LIMIT):
  - Increments each cycle the buffer is non-empty and does not pop.
  - Clears on pop or when the buffer is empty.
- pipe_hold = 0 without WB_STARVE_GUARD_EN.

Optional Feature:
- WB_STARVE_GUARD_EN defined:
  - pipe_hold = non-empty & pipe_eff & (wait_cnt == STARVE_LIMIT).
  - The head pops that cycle, and wait_cnt clears.
  - Worst-case MDU write delay is STARVE_LIMIT+1 cycles.
- WB_STARVE_GUARD_EN not defined:
  - pipe_hold is tied to 0, and the MDU writes only in cycles without pipe_eff.
  - A continuously writing pipeline starves the MDU; the resulting mdu_ready=0 back-pressure is acceptable.

Test Plan:
- Reset release, then pipe_we=1, pipe_rd=5, pipe_data=0xDEADBEEF in cycle N -> rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF in N+1; no hazard_stall.
- Issue with issue_rd=7, then id_rs1=7 -> hazard_stall=1 until an MDU result with rd=7, data=0x12345678 is pushed and popped. The rf write follows one cycle after the pop, and the stall drops the cycle after the pop.
- pipe_eff asserted in the same cycle an MDU result is pushed -> pipe write first, MDU write the next cycle. Exact rf order checked.
- Three MDU results pushed back-to-back while pipe_we=1 continuously (BUF_DEPTH=2) -> mdu_ready=0 after two pushes. Third result held by the MDU, no data lost.
- With WB_STARVE_GUARD_EN and STARVE_LIMIT=4, buffered result plus continuous pipe writes -> pipe_hold=1 exactly in the 5th waiting cycle; MDU write appears on rf the next cycle; the held pipe write appears the cycle after.
- Pipe and MDU writes to rd=0 -> rf_we stays 0; issue with issue_rd=0 -> scoreboard unchanged, issue_ready=1. Assert rst mid-buffer -> buffer empty, scoreboard 0 immediately.
